aes_block_loader: RTL and testbench
===================================

Name: aes_block_loader

Overview:
- Upstream stage of the AES cipher/decipher top level.
- Accepts a byte stream over a valid/ready handshake and assembles the cipher key (16/24/32 bytes, per key-size select) followed by the 128-bit plaintext.
- Presents both as stable parallel big-endian vectors with a done strobe and a level valid flag, which gate the cipher's round stepping.
- Replaces the hard-coded key/text constants of the top level.

Parameters:
- TEXT_BYTES, 16, plaintext length in bytes; fixed by AES, exposed for the bench only.
- MAX_KEY_BYTES, 32, width of the key buffer in bytes (key_out is 8*MAX_KEY_BYTES bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- key_sel  input  2  key size: 0=128, 1=192, 2=256, 3=treated as 128; sampled only when start is accepted.
- start  input  1  begin a new load; honoured in IDLE or DONE, ignored otherwise.
- in_byte  input  8  stream data byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- key_out  output  256  assembled key, [0:255] ordering; the first key byte lands in key_out[0:7].
- text_out  output  128  assembled plaintext, [0:127] ordering; the first text byte lands in text_out[0:7].
- key_sel_q  output  2  latched key size (0/1/2) for the downstream selector.
- load_done  output  1  one-cycle pulse when the last byte is accepted.
- data_valid  output  1  high from load_done until the next accepted start or reset.
- busy  output  1  high in LOAD_KEY and LOAD_TEXT.
- byte_cnt  output  6  bytes accepted in the current phase.

Behaviour:
- Transfer occurs on a clock edge where in_valid && in_ready.
  - in_ready = busy; combinational from state only, never from in_valid.
- States: IDLE, LOAD_KEY, LOAD_TEXT, DONE.
  - IDLE --start--> LOAD_KEY.
  - LOAD_KEY --last key byte transferred--> LOAD_TEXT.
  - LOAD_TEXT --16th byte transferred--> DONE.
  - DONE --start--> LOAD_KEY.
- On accepted start:
  - Latch key_sel (3 becomes 0).
  - Clear key_out and text_out to zero, so unused key bytes read 0 for 128/192.
  - Clear byte_cnt and data_valid.
  - The next cycle is in LOAD_KEY with in_ready=1.
- Key length N = 16/24/32 for key_sel_q = 0/1/2.
  - Byte k (0-based) is written to key_out[8k:8k+7].
  - byte_cnt increments per transfer; on the transfer with byte_cnt==N-1, byte_cnt resets to 0 and the state moves to LOAD_TEXT.
- LOAD_TEXT: byte k is written to text_out[8k:8k+7]. On the transfer with byte_cnt==15:
  - Move to DONE.
  - load_done=1 for exactly that following cycle.
  - data_valid=1.
- Latency: load_done is asserted the cycle after the final transfer. With in_valid held high, a full load takes N+16 cycles after start plus 1.
- Wait states: in_valid low stalls the load indefinitely; no timeout.
- Bytes offered in IDLE/DONE are not accepted (in_ready=0) and have no effect.
- start asserted while busy is ignored; the load in progress continues unchanged.
- start and in_valid in the same IDLE cycle: only start takes effect; the byte is not consumed.
- Outputs stay stable in DONE until the next accepted start.
- Reset, asynchronous at any time including mid-load:
  - state=IDLE.
  - key_out=0, text_out=0, key_sel_q=0, byte_cnt=0.
  - load_done=0, data_valid=0, busy=0, in_ready=0.

Optional Feature:
- Macro: AES_LOADER_CHECKSUM_EN.
- Defined:
  - After the 16th text byte, a CHECK state accepts one extra byte (in_ready=1).
  - If it equals the XOR of all key and text bytes received, go to DONE as above.
  - Otherwise go to IDLE and pulse an extra output chk_err (1 bit, reset 0) for one cycle; data_valid stays 0.
  - chk_err exists only when the macro is defined.
- Undefined: no CHECK state, no chk_err port; DONE follows the 16th text byte directly.

Decomposition:
- Shared package aes_pkg:
  - state enum for the loader.
  - key-size encoding constants KEY128=0, KEY192=1, KEY256=2.
  - function key_bytes(sel) returning 16/24/32.
  - TEXT_BYTES constant.
- No sub-module needed. The byte-write decode (indexed part-select into key/text buffers) stays inline.

Test Plan:
- Reset during LOAD_KEY after 5 bytes -> all outputs 0 immediately, state IDLE, in_ready=0; a subsequent full load still succeeds.
- key_sel=0, stream bytes 00..0f then 00 11 22 .. ff with in_valid held high:
  - key_out[0:127]=000102..0f, key_out[128:255]=0.
  - text_out=00112233445566778899aabbccddeeff.
  - load_done pulses once, 33 cycles after start.
- key_sel=2, bytes 00..1f then the same text -> key_out=000102..1f; key_sel_q=2.
- key_sel=1 with in_valid toggling every other cycle, start pulsed mid-load, key_sel=3 on a later start:
  - 40 transfers completed exactly.
  - Mid-load start ignored.
  - key_sel=3 latches 0.
- In DONE, assert start with in_valid=1 and byte 0xAA in the same cycle:
  - data_valid drops.
  - Buffers cleared.
  - 0xAA not consumed; the next byte becomes key byte 0.
- With AES_LOADER_CHECKSUM_EN:
  - Correct XOR byte -> DONE, data_valid=1.
  - Wrong byte -> chk_err pulse, state IDLE, data_valid=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES block loader: loader states,
// key-size encodings and the key-length lookup.
package aes_pkg;

   localparam int TEXT_BYTES = 16;

   localparam logic [1:0] KEY128 = 2'd0;
   localparam logic [1:0] KEY192 = 2'd1;
   localparam logic [1:0] KEY256 = 2'd2;

   // ST_CHECK is only reachable when the checksum byte is enabled.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_KEY,
      ST_LOAD_TEXT,
      ST_CHECK,
      ST_DONE
   } loader_state_e;

   function automatic logic [5:0] key_bytes(input logic [1:0] sel);
      case (sel)
         KEY192:  return 6'd24;
         KEY256:  return 6'd32;
         default: return 6'd16;
      endcase
   endfunction

endpackage

// File: rtl/aes_block_loader_if.sv
// Byte-stream valid/ready channel feeding the AES block loader.
interface aes_block_loader_if;

   logic [7:0] in_byte;
   logic       in_valid;
   logic       in_ready;

   modport master (
      output in_byte,
      output in_valid,
      input  in_ready
   );

   modport slave (
      input  in_byte,
      input  in_valid,
      output in_ready
   );

endinterface

// File: rtl/aes_block_loader.sv
// Assembles the AES key (16/24/32 bytes) and the 128-bit plaintext from a byte
// stream into stable big-endian vectors. Optional macro AES_LOADER_CHECKSUM_EN
// adds a trailing XOR checksum byte and the chk_err pulse.
module aes_block_loader
   import aes_pkg::*;
#(
   parameter int TEXT_BYTES    = 16,
   parameter int MAX_KEY_BYTES = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [1:0]                     key_sel,
   input  logic                           start,
   aes_block_loader_if.slave              stream,
   output logic [0:8*MAX_KEY_BYTES-1]     key_out,
   output logic [0:8*TEXT_BYTES-1]        text_out,
   output logic [1:0]                     key_sel_q,
   output logic                           load_done,
   output logic                           data_valid,
   output logic                           busy,
   output logic [5:0]                     byte_cnt
`ifdef AES_LOADER_CHECKSUM_EN
   ,
   output logic                           chk_err
`endif
);

   loader_state_e                 state_q, state_d;
   logic [0:8*MAX_KEY_BYTES-1]    key_q, key_d;
   logic [0:8*TEXT_BYTES-1]       text_q, text_d;
   logic [5:0]                    cnt_q, cnt_d;
   logic [1:0]                    sel_q, sel_d;
   logic                          done_q, done_d;
   logic                          valid_q, valid_d;
`ifdef AES_LOADER_CHECKSUM_EN
   logic [7:0]                    sum_q, sum_d;
   logic                          err_q, err_d;
`endif

   logic       xfer;
   logic       accepting;
   logic [1:0] sel_norm;
   logic [5:0] last_key_idx;

   // in_ready depends on state alone so the upstream can never form a loop through it.
   always_comb begin
      accepting = (state_q == ST_LOAD_KEY) || (state_q == ST_LOAD_TEXT);
`ifdef AES_LOADER_CHECKSUM_EN
      accepting = accepting || (state_q == ST_CHECK);
`endif
   end

   assign xfer         = stream.in_valid && accepting;
   assign sel_norm     = (key_sel == KEY192 || key_sel == KEY256) ? key_sel : KEY128;
   assign last_key_idx = key_bytes(sel_q) - 6'd1;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      text_d  = text_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      done_d  = 1'b0;
      valid_d = valid_q;
`ifdef AES_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = 1'b0;
`endif

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD_KEY;
               sel_d   = sel_norm;
               key_d   = '0;
               text_d  = '0;
               cnt_d   = '0;
               valid_d = 1'b0;
`ifdef AES_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end

         ST_LOAD_KEY: begin
            if (xfer) begin
               key_d[8*int'(cnt_q) +: 8] = stream.in_byte;
`ifdef AES_LOADER_CHECKSUM_EN
               sum_d = sum_q ^ stream.in_byte;
`endif
               if (cnt_q == last_key_idx) begin
                  cnt_d   = '0;
                  state_d = ST_LOAD_TEXT;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end

         ST_LOAD_TEXT: begin
            if (xfer) begin
               text_d[8*int'(cnt_q) +: 8] = stream.in_byte;
               cnt_d = cnt_q + 6'd1;
`ifdef AES_LOADER_CHECKSUM_EN
               sum_d = sum_q ^ stream.in_byte;
               if (cnt_q == 6'(TEXT_BYTES - 1)) begin
                  state_d = ST_CHECK;
               end
`else
               if (cnt_q == 6'(TEXT_BYTES - 1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  valid_d = 1'b1;
               end
`endif
            end
         end

`ifdef AES_LOADER_CHECKSUM_EN
         // A bad checksum abandons the block; buffers stay as loaded but are never flagged valid.
         ST_CHECK: begin
            if (xfer) begin
               if (stream.in_byte == sum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  valid_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         text_q  <= '0;
         cnt_q   <= '0;
         sel_q   <= KEY128;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef AES_LOADER_CHECKSUM_EN
         sum_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         text_q  <= text_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         done_q  <= done_d;
         valid_q <= valid_d;
`ifdef AES_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end

   assign stream.in_ready = accepting;
   assign busy            = accepting;
   assign key_out         = key_q;
   assign text_out        = text_q;
   assign key_sel_q       = sel_q;
   assign load_done       = done_q;
   assign data_valid      = valid_q;
   assign byte_cnt        = cnt_q;
`ifdef AES_LOADER_CHECKSUM_EN
   assign chk_err         = err_q;
`endif

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader; also exercises the checksum byte when
// AES_LOADER_CHECKSUM_EN is defined.
module tb_aes_block_loader;
   import aes_pkg::*;

`ifdef AES_LOADER_CHECKSUM_EN
   localparam int CHK_EXTRA = 1;
`else
   localparam int CHK_EXTRA = 0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   key_sel;
   logic         start;
   logic [0:255] key_out;
   logic [0:127] text_out;
   logic [1:0]   key_sel_q;
   logic         load_done;
   logic         data_valid;
   logic         busy;
   logic [5:0]   byte_cnt;
`ifdef AES_LOADER_CHECKSUM_EN
   logic         chk_err;
   logic [7:0]   chk_mask;
`endif

   aes_block_loader_if bus ();

   aes_block_loader #(
      .TEXT_BYTES    (16),
      .MAX_KEY_BYTES (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_sel    (key_sel),
      .start      (start),
      .stream     (bus),
      .key_out    (key_out),
      .text_out   (text_out),
      .key_sel_q  (key_sel_q),
      .load_done  (load_done),
      .data_valid (data_valid),
      .busy       (busy),
      .byte_cnt   (byte_cnt)
`ifdef AES_LOADER_CHECKSUM_EN
      ,
      .chk_err    (chk_err)
`endif
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   int         cycle  = 0;
   int         xfers  = 0;
   int         pulses = 0;
   logic [7:0] xor_acc;

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (bus.in_valid && bus.in_ready) xfers <= xfers + 1;
      if (load_done) pulses <= pulses + 1;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one byte after 'gap' idle cycles; returns 1 time unit after its transfer edge.
   task automatic send(input logic [7:0] b, input int gap);
      int guard;
      bus.in_valid = 1'b0;
      repeat (gap) tick();
      bus.in_byte  = b;
      bus.in_valid = 1'b1;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("ready_timeout", 256'(bus.in_ready), 256'(1));
      tick();
      bus.in_valid = 1'b0;
      xor_acc = xor_acc ^ b;
   endtask

   // Key byte k = kbase+k; text byte k = tmul*k + tbase. poke_at pulses start mid key phase.
   task automatic load_seq(input logic [1:0] sel, input int nkey, input logic [7:0] kbase,
                           input logic [7:0] tmul, input logic [7:0] tbase,
                           input int gap, input int poke_at, output int lat);
      int         t0;
      logic [7:0] b;
      key_sel = sel;
      start   = 1'b1;
      t0      = cycle;
      tick();
      start   = 1'b0;
      pulses  = 0;
      xor_acc = 8'h00;
      for (int k = 0; k < nkey; k++) begin
         if (k == poke_at) begin
            check("mid_byte_cnt", 256'(byte_cnt), 256'(k));
            key_sel = 2'd2;
            start   = 1'b1;
            tick();
            start   = 1'b0;
            check("mid_start_busy", 256'(busy), 256'(1));
         end
         b = kbase + 8'(k);
         send(b, gap);
      end
      for (int k = 0; k < 16; k++) begin
         b = tmul * 8'(k) + tbase;
         send(b, gap);
      end
`ifdef AES_LOADER_CHECKSUM_EN
      b = xor_acc ^ chk_mask;
      send(b, gap);
`endif
      lat = cycle - t0;
      $display("load sel=%0d key=%h text=%h lat=%0d", sel, key_out, text_out, lat);
   endtask

   int lat;
   int x0;

   initial begin
      rst          = 1'b1;
      key_sel      = 2'd0;
      start        = 1'b0;
      bus.in_byte  = 8'h00;
      bus.in_valid = 1'b0;
      xor_acc      = 8'h00;
`ifdef AES_LOADER_CHECKSUM_EN
      chk_mask     = 8'h00;
`endif
      repeat (3) tick();
      check("rst_key", 256'(key_out), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_ready", 256'(bus.in_ready), 256'(0));
      check("rst_valid", 256'(data_valid), 256'(0));
      rst = 1'b0;
      tick();

      // Abort a 256-bit load after 5 key bytes with an asynchronous reset.
      key_sel = 2'd2;
      start   = 1'b1;
      tick();
      start   = 1'b0;
      for (int k = 0; k < 5; k++) send(8'(k + 1), 0);
      check("pre_rst_cnt", 256'(byte_cnt), 256'(5));
      #3 rst = 1'b1;
      #1;
      check("arst_key", 256'(key_out), 256'(0));
      check("arst_cnt", 256'(byte_cnt), 256'(0));
      check("arst_sel", 256'(key_sel_q), 256'(0));
      check("arst_busy", 256'(busy), 256'(0));
      check("arst_ready", 256'(bus.in_ready), 256'(0));
      tick();
      rst = 1'b0;
      tick();

      // 128-bit key, in_valid held high.
      load_seq(2'd0, 16, 8'h00, 8'h11, 8'h00, 0, -1, lat);
      check("k128_key", key_out,
            256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000);
      check("k128_text", 256'(text_out), 256'(128'h00112233445566778899aabbccddeeff));
      check("k128_done", 256'(load_done), 256'(1));
      check("k128_lat", 256'(lat), 256'(33 + CHK_EXTRA));
      repeat (2) tick();
      check("k128_pulses", 256'(pulses), 256'(1));
      check("k128_valid_hold", 256'(data_valid), 256'(1));

      // 256-bit key.
      load_seq(2'd2, 32, 8'h00, 8'h11, 8'h00, 0, -1, lat);
      check("k256_key", key_out,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      check("k256_sel", 256'(key_sel_q), 256'(2));
      check("k256_lat", 256'(lat), 256'(49 + CHK_EXTRA));

      // 192-bit key, in_valid toggling, start pulsed mid-load.
      x0 = xfers;
      load_seq(2'd1, 24, 8'h40, 8'h01, 8'ha0, 1, 10, lat);
      check("k192_xfers", 256'(xfers - x0), 256'(40 + CHK_EXTRA));
      check("k192_key", key_out,
            256'h404142434445464748494a4b4c4d4e4f5051525354555657_0000000000000000);
      check("k192_text", 256'(text_out), 256'(128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf));
      check("k192_sel", 256'(key_sel_q), 256'(1));
      check("k192_valid", 256'(data_valid), 256'(1));

      // key_sel=3 behaves as 128.
      load_seq(2'd3, 16, 8'h80, 8'h01, 8'h30, 0, -1, lat);
      check("k3_sel", 256'(key_sel_q), 256'(0));
      check("k3_key", key_out,
            256'h808182838485868788898a8b8c8d8e8f_00000000000000000000000000000000);
      check("k3_text", 256'(text_out), 256'(128'h303132333435363738393a3b3c3d3e3f));

      // Start and a byte together in DONE: only start takes effect.
      key_sel      = 2'd1;
      start        = 1'b1;
      bus.in_byte  = 8'haa;
      bus.in_valid = 1'b1;
      x0 = xfers;
      tick();
      start = 1'b0;
      check("rs_valid", 256'(data_valid), 256'(0));
      check("rs_key", key_out, 256'(0));
      check("rs_text", 256'(text_out), 256'(0));
      check("rs_cnt", 256'(byte_cnt), 256'(0));
      check("rs_busy", 256'(busy), 256'(1));
      check("rs_no_xfer", 256'(xfers - x0), 256'(0));
      bus.in_byte = 8'h5c;
      tick();
      bus.in_valid = 1'b0;
      check("rs_first_byte", key_out, {8'h5c, 248'h0});
      check("rs_cnt1", 256'(byte_cnt), 256'(1));
      $display("restart first key byte=%h", key_out[0:7]);

`ifdef AES_LOADER_CHECKSUM_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk_mask = 8'h00;
      load_seq(2'd0, 16, 8'h10, 8'h01, 8'h55, 0, -1, lat);
      check("chk_ok_valid", 256'(data_valid), 256'(1));
      check("chk_ok_err", 256'(chk_err), 256'(0));
      chk_mask = 8'h01;
      load_seq(2'd0, 16, 8'h10, 8'h01, 8'h55, 0, -1, lat);
      check("chk_bad_err", 256'(chk_err), 256'(1));
      check("chk_bad_busy", 256'(busy), 256'(0));
      check("chk_bad_valid", 256'(data_valid), 256'(0));
      check("chk_bad_done", 256'(load_done), 256'(0));
      tick();
      check("chk_err_pulse", 256'(chk_err), 256'(0));
      chk_mask = 8'h00;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
